// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_WAIT    = 2'b01,
    ST_DISCARD = 2'b10,
    ST_HALT    = 2'b11
  } fetch_state_e;

  localparam int unsigned INST_STEP        = 4;
  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam int unsigned DEPTH_DEFAULT    = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // A target is misaligned when either of its two low address bits is set.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; the head entry is read straight from storage
// registers so the output never depends combinationally on the write data.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * XLEN_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop; a flush voids both, and a full FIFO accepts a push only alongside a pop.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (flush) begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
    end else begin
      do_pop_s  = pop && (count_r != CW'(0));
      do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
  assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// prefetch FIFO, with redirect flushing and sticky misaligned-target halt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEFAULT,
  parameter int unsigned      DEPTH    = DEPTH_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i,
  output logic            misalign_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_r;
  fetch_state_e      state_next_s;
  fetch_state_e      resolved_state_s;
  logic [XLEN-1:0]   fetch_pc_r;
  logic [XLEN-1:0]   req_pc_r;
  logic              misalign_r;
  logic              misalign_next_s;
  logic              fire_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CW-1:0]     fifo_count_s;
  logic [2*XLEN-1:0] fifo_dout_s;

  assign imem_req_o   = (state_r == ST_RUN) && (fifo_count_s < CW'(DEPTH));
  assign imem_addr_o  = fetch_pc_r;
  assign fire_s       = imem_req_o && imem_gnt_i;
  assign inst_valid_o = !fifo_empty_s;
  // Redirect wins over both a same-cycle response and a same-cycle pop.
  assign push_s       = (state_r == ST_WAIT) && imem_rvalid_i && !redirect_i && !fifo_full_s;
  assign pop_s        = !fifo_empty_s && inst_ready_i && !redirect_i;
  assign inst_o       = fifo_dout_s[2*XLEN-1:XLEN];
  assign inst_pc_o    = fifo_dout_s[XLEN-1:0];
  assign misalign_o   = misalign_r;

  // Next-state: once nothing is outstanding, the sticky flag picks HALT or RUN.
  always_comb begin
    state_next_s     = state_r;
    misalign_next_s  = misalign_r;
    resolved_state_s = ST_RUN;
    if (redirect_i) begin
      misalign_next_s = is_misaligned(redirect_pc_i[1:0]);
    end else begin
      misalign_next_s = misalign_r;
    end
    resolved_state_s = misalign_next_s ? ST_HALT : ST_RUN;
    case (state_r)
      ST_RUN: begin
        if (redirect_i) begin
          state_next_s = fire_s ? ST_DISCARD : resolved_state_s;
        end else begin
          state_next_s = fire_s ? ST_WAIT : ST_RUN;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_next_s = resolved_state_s;
        end else begin
          state_next_s = redirect_i ? ST_DISCARD : ST_WAIT;
        end
      end
      ST_DISCARD: begin
        state_next_s = imem_rvalid_i ? resolved_state_s : ST_DISCARD;
      end
      ST_HALT: begin
        state_next_s = resolved_state_s;
      end
      default: begin
        state_next_s = ST_RUN;
      end
    endcase
  end

  // State, fetch address, in-flight request address and sticky misalign flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_RUN;
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= RESET_PC;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      misalign_r <= misalign_next_s;
      if (redirect_i) begin
        fetch_pc_r <= redirect_pc_i;
      end else if (fire_s) begin
        fetch_pc_r <= fetch_pc_r + XLEN'(INST_STEP);
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      if (fire_s) req_pc_r <= fetch_pc_r;
    end
  end

  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_i),
    .din   ({imem_rdata_i, req_pc_r}),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with default parameters.
module tb_fetch_unit;

  logic        clk;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i),
    .misalign_o    (misalign_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; inst_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL reset_req: got %b expected 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign_o); end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    inst_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 32'(4 * i);
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== a) begin errors++; $display("FAIL seq_req: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, a); end
      if (i > 0) begin
        checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== a - 32'd4 || inst_o !== mem_word(a - 32'd4)) begin errors++; $display("FAIL seq_inst: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", inst_valid_o, inst_pc_o, inst_o, a - 32'd4, mem_word(a - 32'd4)); end
      end else begin
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL seq_first_valid: got %b expected 0", inst_valid_o); end
      end
      imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0;
      @(negedge clk);
      checks++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL seq_wait: got req=%b v=%b expected req=0 v=0", imem_req_o, inst_valid_o); end
      imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(a);
      @(negedge clk);
    end
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'd20 || imem_addr_o !== 32'd24) begin errors++; $display("FAIL seq_last: got v=%b pc=%h addr=%h expected v=1 pc=14 addr=18", inst_valid_o, inst_pc_o, imem_addr_o); end
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] p;
    p = 32'd24;
    inst_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== p + 32'(4 * i)) begin errors++; $display("FAIL bp_fill_req: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, p + 32'(4 * i)); end
      imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0;
      @(negedge clk);
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(p + 32'(4 * i));
      @(negedge clk);
    end
    imem_rvalid_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b1 || inst_pc_o !== p) begin errors++; $display("FAIL bp_full: got req=%b v=%b pc=%h expected req=0 v=1 pc=%h", imem_req_o, inst_valid_o, inst_pc_o, p); end
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_full_hold: got req=%b expected 0", imem_req_o); end
    inst_ready_i = 1'b1;
    @(negedge clk);
    inst_ready_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== p + 32'd16 || inst_pc_o !== p + 32'd4) begin errors++; $display("FAIL bp_one_pop: got req=%b addr=%h pc=%h expected req=1 addr=%h pc=%h", imem_req_o, imem_addr_o, inst_pc_o, p + 32'd16, p + 32'd4); end
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_refill_wait: got req=%b expected 0", imem_req_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(p + 32'd16);
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_refull: got req=%b expected 0", imem_req_o); end
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_single_request: got req=%b expected 0", imem_req_o); end
    inst_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== p + 32'(4 * i) || inst_o !== mem_word(p + 32'(4 * i))) begin errors++; $display("FAIL bp_drain: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", inst_valid_o, inst_pc_o, inst_o, p + 32'(4 * i), mem_word(p + 32'(4 * i))); end
      @(negedge clk);
    end
    checks++; if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== p + 32'd20) begin errors++; $display("FAIL bp_drained: got v=%b req=%b addr=%h expected v=0 req=1 addr=%h", inst_valid_o, imem_req_o, imem_addr_o, p + 32'd20); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL rw_discard: got req=%b v=%b expected req=0 v=0", imem_req_o, inst_valid_o); end
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rw_discard_hold: got req=%b expected 0", imem_req_o); end
    @(negedge clk);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL rw_new_req: got req=%b addr=%h v=%b expected req=1 addr=100 v=0", imem_req_o, imem_addr_o, inst_valid_o); end
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h100);
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h100 || inst_o !== mem_word(32'h100)) begin errors++; $display("FAIL rw_first_inst: got v=%b pc=%h inst=%h expected v=1 pc=100 inst=%h", inst_valid_o, inst_pc_o, inst_o, mem_word(32'h100)); end
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rw_popped: got v=%b expected 0", inst_valid_o); end
  endtask

  task automatic test_redirect_rvalid();
    inst_ready_i = 1'b0; imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h104);
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h104 || imem_addr_o !== 32'h108) begin errors++; $display("FAIL rr_setup: got v=%b pc=%h addr=%h expected v=1 pc=104 addr=108", inst_valid_o, inst_pc_o, imem_addr_o); end
    @(negedge clk);
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h108); inst_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    @(negedge clk);
    imem_rvalid_i = 1'b0; inst_ready_i = 1'b0; redirect_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin errors++; $display("FAIL rr_flush: got v=%b req=%b addr=%h expected v=0 req=1 addr=200", inst_valid_o, imem_req_o, imem_addr_o); end
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rr_no_push: got v=%b expected 0", inst_valid_o); end
    inst_ready_i = 1'b1;
  endtask

  task automatic test_misalign();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++; if (misalign_o !== 1'b1 || imem_req_o !== 1'b0) begin errors++; $display("FAIL ma_set: got mis=%b req=%b expected mis=1 req=0", misalign_o, imem_req_o); end
    imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || misalign_o !== 1'b1) begin errors++; $display("FAIL ma_halt: got req=%b v=%b mis=%b expected req=0 v=0 mis=1", imem_req_o, inst_valid_o, misalign_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0306;
    @(negedge clk);
    checks++; if (misalign_o !== 1'b1 || imem_req_o !== 1'b0) begin errors++; $display("FAIL ma_rehalt: got mis=%b req=%b expected mis=1 req=0", misalign_o, imem_req_o); end
    redirect_pc_i = 32'h0000_0300;
    @(negedge clk);
    redirect_i = 1'b0; imem_gnt_i = 1'b0;
    checks++; if (misalign_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin errors++; $display("FAIL ma_exit: got mis=%b req=%b addr=%h expected mis=0 req=1 addr=300", misalign_o, imem_req_o, imem_addr_o); end
  endtask

  task automatic test_misalign_pending();
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_00FE;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++; if (misalign_o !== 1'b1 || imem_req_o !== 1'b0) begin errors++; $display("FAIL mp_set: got mis=%b req=%b expected mis=1 req=0", misalign_o, imem_req_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL mp_dropped: got req=%b v=%b expected req=0 v=0", imem_req_o, inst_valid_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC || misalign_o !== 1'b0) begin errors++; $display("FAIL mp_exit: got req=%b addr=%h mis=%b expected req=1 addr=fffffffc mis=0", imem_req_o, imem_addr_o, misalign_o); end
  endtask

  task automatic test_wrap();
    inst_ready_i = 1'b0; imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'hFFFF_FFFC);
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr: got req=%b addr=%h expected req=1 addr=0", imem_req_o, imem_addr_o); end
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'hFFFF_FFFC || inst_o !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_inst: got v=%b pc=%h inst=%h expected v=1 pc=fffffffc inst=%h", inst_valid_o, inst_pc_o, inst_o, mem_word(32'hFFFF_FFFC)); end
    inst_ready_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    imem_gnt_i = 1'b1;
    @(negedge clk);
    imem_gnt_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_wait_pre: got req=%b expected 0", imem_req_o); end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_wait_req: got req=%b addr=%h v=%b expected req=1 addr=0 v=0", imem_req_o, imem_addr_o, inst_valid_o); end
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_wait_stale: got v=%b expected 0", inst_valid_o); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid();
    test_misalign();
    test_misalign_pending();
    test_wrap();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning address/instruction width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning prefetch FIFO entries; power of two, 2..16.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address.
REQ-004 The block SHALL have ports clk_i in 1 (sole clock) and rst_i in 1 (reset: synchronous, active-high).
REQ-005 The block SHALL have ports redirect_i in 1 (taken branch/jump) and redirect_pc_i in XLEN (new target).
REQ-006 The block SHALL have ports imem_req_o out 1 and imem_addr_o out XLEN (fetch request and its address).
REQ-007 The block SHALL have ports imem_gnt_i in 1 (request accepted this cycle), imem_rvalid_i in 1 and imem_rdata_i in XLEN (response).
REQ-008 The block SHALL have ports inst_valid_o out 1, inst_o out XLEN, inst_pc_o out XLEN and inst_ready_i in 1 (decode handshake).
REQ-009 The block SHALL have port misalign_o out 1 (sticky instruction-address-misaligned flag).

Function
REQ-010 FSM SHALL have states RUN (may request), WAIT (one response pending), DISCARD (pending response to be dropped), HALT (misaligned target).
REQ-011 In RUN, imem_req_o SHALL be high iff FIFO occupancy < DEPTH; imem_addr_o = fetch_pc; request held stable until imem_gnt_i.
REQ-012 On req && gnt: fetch_pc <= fetch_pc + 4 (mod 2^XLEN, wrap silent); state -> WAIT.
REQ-013 At most one request SHALL be outstanding; imem_req_o low in WAIT, DISCARD and HALT.
REQ-014 In WAIT, on imem_rvalid_i: push {imem_rdata_i, pc of that request} into FIFO; -> RUN.
REQ-015 imem_rvalid_i with no request outstanding (RUN, HALT) SHALL be ignored.
REQ-016 inst_valid_o = FIFO not empty; inst_o/inst_pc_o = head entry; pop on inst_valid_o && inst_ready_i.
REQ-017 Push and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-018 redirect_i SHALL flush the FIFO next edge (inst_valid_o low the following cycle) and load fetch_pc <= redirect_pc_i.
REQ-019 redirect_i has priority: a same-cycle pop is void, a same-cycle imem_rvalid_i response is dropped.
REQ-020 redirect_i in WAIT (without rvalid) -> DISCARD; in DISCARD stays DISCARD with the newer target; DISCARD -> RUN on imem_rvalid_i, data dropped.
REQ-021 redirect_i in RUN with same-cycle gnt: the granted request SHALL be treated as outstanding and discarded (-> DISCARD).
REQ-022 redirect_pc_i[1:0] != 0 SHALL set misalign_o, -> HALT, FIFO flushed; an outstanding response is still consumed and dropped first.
REQ-023 HALT exits only on a redirect with aligned target (-> RUN, misalign_o cleared); misaligned redirect keeps HALT.
REQ-024 Latency: redirect at edge N -> imem_req_o high with new address in cycle N+1 (if nothing outstanding); rvalid at edge M -> inst_valid_o in cycle M+1.

Reset
REQ-025 rst_i high at an edge SHALL set fetch_pc = RESET_PC, state RUN, FIFO empty, misalign_o = 0, inst_valid_o = 0; imem_req_o high in the first cycle after reset.
REQ-026 Reset mid-operation SHALL abandon any outstanding request; instruction memory is reset by the same rst_i, and later rvalid is ignored per REQ-015.

Structure
REQ-027 fetch_pkg SHALL hold the FSM state enum, the 4-byte instruction step constant and the parameter defaults.
REQ-028 FIFO SHALL be sub-module sync_fifo (parameters WIDTH=2*XLEN, DEPTH; ports push, pop, flush, full, empty, count).
REQ-029 Outputs inst_o, inst_pc_o SHALL come from FIFO storage registers, with no combinational path from imem_rdata_i.

Verification
REQ-030 Reset, gnt tied high, rvalid one cycle after gnt, ready high -> imem_addr_o 0,4,8,...; inst_pc_o matches; one instruction every 2 cycles.
REQ-031 inst_ready_i low, DEPTH=4 -> exactly 4 pushes then imem_req_o low; single ready pulse -> one pop, then exactly one new request.
REQ-032 Redirect to 0x100 in WAIT; response arrives 3 cycles later -> response dropped, FIFO empty, next request addr 0x100, first inst_pc_o 0x100.
REQ-033 Redirect to 0x200 same cycle as rvalid and ready -> nothing pushed or popped, FIFO empty next cycle, next request addr 0x200.
REQ-034 Redirect to 0x102 -> misalign_o=1, no requests; redirect to 0x300 -> misalign_o=0, request 0x300 next cycle.
REQ-035 fetch_pc 0xFFFF_FFFC granted -> next request addr 0x0000_0000; rst_i asserted in WAIT -> request at RESET_PC, stale rvalid ignored.
